// File: rtl/pattern_lut_rdbk_arb_if.sv
// VME readback handshake between the register decoder (master) and the LUT
// port-1 arbiter (slave).
interface pattern_lut_rdbk_arb_if #(
    parameter int unsigned MXADRB = 12,
    parameter int unsigned MXDATB = 18,
    parameter int unsigned MXPIDB = 4
);
    logic              vme_rd_req;
    logic [MXPIDB-1:0] vme_rd_pid;
    logic [MXADRB-1:0] vme_rd_adr;
    logic              vme_rd_busy;
    logic              vme_rd_done;
    logic              vme_rd_err;
    logic [MXDATB-1:0] vme_rd_data;

    modport master (
        output vme_rd_req, vme_rd_pid, vme_rd_adr,
        input  vme_rd_busy, vme_rd_done, vme_rd_err, vme_rd_data
    );

    modport slave (
        input  vme_rd_req, vme_rd_pid, vme_rd_adr,
        output vme_rd_busy, vme_rd_done, vme_rd_err, vme_rd_data
    );
endinterface

// File: rtl/pattern_lut_rdbk_arb.sv
// Shares pattern LUT port 1 between the CLCT finder and VME readback; the finder
// keeps priority unless it starves a pending readback for STARVE_MAX cycles.
module pattern_lut_rdbk_arb #(
    parameter int unsigned MXADRB     = 12,
    parameter int unsigned MXDATB     = 18,
    parameter int unsigned MXPIDB     = 4,
    parameter logic [10:0] PAT_EN     = 11'h7FC,
    parameter int unsigned STARVE_MAX = 15,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clct_vld0,
    input  logic                    clct_vld1,
    input  logic [MXADRB-1:0]       clct_adr0,
    input  logic [MXADRB-1:0]       clct_adr1,
    input  logic [MXPIDB-1:0]       clct_pid0,
    input  logic [MXPIDB-1:0]       clct_pid1,
    input  logic                    steal_cnt_clr,
    input  logic [MXDATB-1:0]       rom_rd1,
    output logic [MXADRB-1:0]       rom_adr0,
    output logic [MXPIDB-1:0]       rom_pid0,
    output logic [MXADRB-1:0]       rom_adr1,
    output logic [MXPIDB-1:0]       rom_pid1,
    output logic                    clct_stall,
    output logic [7:0]              steal_cnt,
    pattern_lut_rdbk_arb_if.slave   vme
);
    localparam int unsigned NumPid = 1 << MXPIDB;
    localparam logic [NumPid-1:0] PatEnExt = NumPid'(PAT_EN);

    typedef enum logic [1:0] {StIdle, StWaitSlot, StWaitData, StDone} state_e;

    state_e            state_q, state_d;
    logic [MXPIDB-1:0] pid_q;
    logic [MXADRB-1:0] adr_q;
    logic [7:0]        starve_q, starve_d;
    logic [1:0]        lat_q, lat_d;
    logic [7:0]        steal_q, steal_d;
    logic              busy_q, done_q;
    logic              err_q, err_d;
    logic [MXDATB-1:0] data_q, data_d;
    logic              latch;
    logic              pid_ok;

    // Port-0 valid belongs to the finder's own pipeline; nothing here consumes it.
    logic unused_vld0;
    assign unused_vld0 = clct_vld0;

    assign rom_adr0 = clct_adr0;
    assign rom_pid0 = clct_pid0;

    assign pid_ok = (vme.vme_rd_pid >= MXPIDB'(2)) && (vme.vme_rd_pid <= MXPIDB'(10)) &&
                    PatEnExt[vme.vme_rd_pid];

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        err_d      = err_q;
        data_d     = data_q;
        latch      = 1'b0;
        rom_adr1   = clct_adr1;
        rom_pid1   = clct_pid1;
        clct_stall = 1'b0;

        case (state_q)
            StIdle: begin
                if (vme.vme_rd_req) begin
                    latch = 1'b1;
                    if (pid_ok) begin
                        starve_d = '0;
                        state_d  = StWaitSlot;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = StDone;
                    end
                end
            end
            StWaitSlot: begin
                // Grant in the same cycle: finder idle, or it has starved us long enough.
                if (!clct_vld1 || (starve_q == 8'(STARVE_MAX))) begin
                    rom_adr1   = adr_q;
                    rom_pid1   = pid_q;
                    clct_stall = clct_vld1;
                    lat_d      = '0;
                    state_d    = StWaitData;
                end else begin
                    starve_d = starve_q + 8'd1;
                end
            end
            StWaitData: begin
                if (lat_q == 2'(RD_LAT - 1)) begin
                    data_d  = rom_rd1;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (steal_cnt_clr) begin
            steal_d = '0;
        end else if (clct_stall && (steal_q != 8'hFF)) begin
            steal_d = steal_q + 8'd1;
        end else begin
            steal_d = steal_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pid_q    <= '0;
            adr_q    <= '0;
            starve_q <= '0;
            lat_q    <= '0;
            steal_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lat_q    <= lat_d;
            steal_q  <= steal_d;
            busy_q   <= (state_d != StIdle);
            done_q   <= (state_d == StDone);
            err_q    <= err_d;
            data_q   <= data_d;
            if (latch) begin
                pid_q <= vme.vme_rd_pid;
                adr_q <= vme.vme_rd_adr;
            end
        end
    end

    assign vme.vme_rd_busy = busy_q;
    assign vme.vme_rd_done = done_q;
    assign vme.vme_rd_err  = err_q;
    assign vme.vme_rd_data = data_q;
    assign steal_cnt       = steal_q;
endmodule

// File: doc/pattern_lut_rdbk_arb.md
Name: pattern_lut_rdbk_arb

Overview:
Arbitrates port 1 of the pattern LUT ROM bank between the CLCT pattern finder and a VME readback path. Port 0 always belongs to the finder. A VME readback of one 18-bit LUT word (offset/bend/quality) takes port 1 only when the finder leaves it idle. If the finder starves the request for STARVE_MAX cycles, the arbiter steals one slot and flags a stall. The block sits between the pattern finder, the pattern LUT and the VME register decoder.

Parameters:
MXADRB, 12, LUT address width (carry word)
MXDATB, 18, LUT data width
MXPIDB, 4, pattern ID width
PAT_EN, 11'h7FC, enabled-pattern mask, bit n = pattern n
STARVE_MAX, 15, finder-busy cycles tolerated before a forced steal (1..255)
RD_LAT, 1, cycles from address issue to valid rom_rd1 (1..3)

Ports:
clock  in  1  main clock, all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
clct_vld0  in  1  finder lookup valid, port 0
clct_vld1  in  1  finder lookup valid, port 1
clct_adr0  in  MXADRB  finder carry address, port 0
clct_adr1  in  MXADRB  finder carry address, port 1
clct_pid0  in  MXPIDB  finder pattern ID, port 0
clct_pid1  in  MXPIDB  finder pattern ID, port 1
vme_rd_req  in  1  readback request, sampled in IDLE only
vme_rd_pid  in  MXPIDB  readback pattern ID
vme_rd_adr  in  MXADRB  readback address
steal_cnt_clr  in  1  synchronous clear of steal_cnt
rom_rd1  in  MXDATB  LUT port-1 read data
rom_adr0  out  MXADRB  LUT port-0 address, equals clct_adr0 (combinational)
rom_pid0  out  MXPIDB  LUT port-0 pid, equals clct_pid0 (combinational)
rom_adr1  out  MXADRB  LUT port-1 address (muxed)
rom_pid1  out  MXPIDB  LUT port-1 pid (muxed)
clct_stall  out  1  the finder's port-1 lookup this cycle was pre-empted
vme_rd_busy  out  1  a readback is in progress
vme_rd_done  out  1  one-cycle completion pulse
vme_rd_err  out  1  valid with done; the pid was invalid
vme_rd_data  out  MXDATB  captured LUT word, held until the next done
steal_cnt  out  8  count of forced steals, saturates at 255

Behaviour:
- Reset (asynchronous, reset_n low):
  - state goes to IDLE.
  - All registered outputs and internal latches go to 0: vme_rd_busy, vme_rd_done, vme_rd_err, vme_rd_data, steal_cnt, starve counter, latency counter.
  - A readback in flight is discarded and no done pulse is produced.
- States: IDLE, WAIT_SLOT, WAIT_DATA, DONE.
- IDLE:
  - On vme_rd_req=1, latch vme_rd_pid and vme_rd_adr.
  - If the pid is outside 2..10, or PAT_EN[pid]=0, go to DONE with err=1.
  - Otherwise go to WAIT_SLOT with the starve counter cleared.
- WAIT_SLOT (the grant is decided combinationally in the same cycle):
  - Grant when clct_vld1=0, or when starve==STARVE_MAX.
  - On grant (the issue cycle): rom_adr1/rom_pid1 = latched values; clct_stall = clct_vld1; steal_cnt increments if clct_stall=1 (saturating); go to WAIT_DATA.
  - No grant: starve increments.
- Port-1 mux when not issuing: rom_adr1/rom_pid1 = clct_adr1/clct_pid1 and clct_stall=0.
- WAIT_DATA:
  - Lasts RD_LAT cycles, covering issue+1 through issue+RD_LAT.
  - At the end of the last cycle, capture rom_rd1 into vme_rd_data; go to DONE.
- DONE:
  - One cycle: vme_rd_done=1; vme_rd_err as decided.
  - On the error path vme_rd_data is loaded with 0.
  - Then go to IDLE.
- vme_rd_busy = (state != IDLE).
- vme_rd_req while busy is ignored. There is no queueing; the requester must re-issue after done.
- vme_rd_req held high in the cycle done is high is not accepted until IDLE, i.e. the following cycle.
- steal_cnt_clr has priority over an increment in the same cycle; the result is 0.
- Port 0 is never touched; finder throughput on port 0 is unaffected.
- Worst-case readback latency = STARVE_MAX + RD_LAT + 2 cycles from the request.

Test Plan:
- Idle finder (clct_vld1=0), req at cycle 0 with pid=5, adr=12'h3A7, rom_rd1=18'h2C0F1 → issue cycle 1 with rom_adr1=12'h3A7 and rom_pid1=5; done at cycle 3; data=18'h2C0F1; err=0; clct_stall never 1; steal_cnt=0.
- clct_vld1 held at 1, req at cycle 0 → rom_adr1 follows clct_adr1 during cycles 1–15; forced issue at cycle 16 with clct_stall=1 for exactly one cycle; done at cycle 18; steal_cnt=1.
- clct_vld1 high for cycles 1–4 and low at cycle 5 → issue at cycle 5 with clct_stall=0; done at cycle 7; steal_cnt unchanged.
- req with pid=1, then pid=11, then an enabled-mask-off pid (PAT_EN=11'h3FC, pid=10) → each gives done one cycle after req, err=1, data=0, and rom_adr1 is never driven from the readback.
- A second req while busy, at cycle 2 in the idle-finder case → ignored; exactly one done pulse, at cycle 3.
- reset_n low at cycle 2, during WAIT_DATA → busy, done, data and steal_cnt are 0 immediately; no done after release; a new req is served normally.
- Stall-forcing requests repeated 300 times → steal_cnt saturates at 255; a steal_cnt_clr pulse coinciding with a steal gives steal_cnt=0.
